// File: rtl/counter_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a 3-digit multiplexed common-anode 7-segment display.
// Latency: value sampled at edge k, bcd/bcd_valid after edge k+8; no backpressure, changes during a conversion wait for IDLE.
module counter_display #(
    parameter int REFRESH_CYCLES = 500,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic [7:0]  value,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int            RW       = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------- converter ----------------
    state_t      state_q;
    logic        busy_q;
    logic        bcd_valid_q;
    logic [11:0] bcd_q;
    logic [7:0]  last_q;
    logic [2:0]  iter_q;
    logic [19:0] sr_q;       // {bcd[11:0], binary[7:0]}
    logic [19:0] sr_d;
    logic [11:0] adj;

    always_comb begin : dabble_step
        adj = sr_q[19:8];
        for (int n = 0; n < 3; n++) begin
            if (adj[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
            end
        end
        sr_d = {adj, sr_q[7:0]} << 1;
    end

    always_ff @(posedge clock) begin : conv_fsm
        if (!clear_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
            bcd_q       <= 12'd0;
            last_q      <= 8'd0;
            iter_q      <= 3'd0;
            sr_q        <= 20'd0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (value != last_q) begin
                        sr_q    <= {12'd0, value};
                        last_q  <= value;
                        iter_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q   <= sr_d;
                    iter_q <= iter_q + 3'd1;
                    // The eighth shift's result goes straight to bcd_q.
                    if (iter_q == 3'd7) begin
                        bcd_q       <= sr_d[19:8];
                        bcd_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------- scanner ----------------
    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          wrap;
    logic [3:0]    nib;
    logic [2:0]    an_slot;
    logic          blank;
    logic          hund_zero;
    logic          tens_zero;

    always_comb begin : scan_next
        wrap      = (refresh_q == REF_LAST);
        refresh_d = wrap ? '0 : refresh_q + 1'b1;
        digit_d   = digit_q;
        seg_d     = seg_q;
        an_d      = an_q;
        nib       = 4'd0;
        an_slot   = 3'b111;
        blank     = 1'b0;
        hund_zero = (bcd_q[11:8] == 4'd0);
        tens_zero = (bcd_q[7:4] == 4'd0);
        if (wrap) begin
            case (digit_q)
                2'd0:    digit_d = 2'd1;
                2'd1:    digit_d = 2'd2;
                default: digit_d = 2'd0;
            endcase
            case (digit_d)
                2'd1: begin
                    nib     = bcd_q[7:4];
                    an_slot = 3'b101;
                    blank   = BLANK_LEADING && hund_zero && tens_zero;
                end
                2'd2: begin
                    nib     = bcd_q[11:8];
                    an_slot = 3'b011;
                    blank   = BLANK_LEADING && hund_zero;
                end
                default: begin
                    nib     = bcd_q[3:0];
                    an_slot = 3'b110;
                end
            endcase
            // A blanked slot keeps its time but lights nothing.
            an_d  = blank ? 3'b111 : an_slot;
            seg_d = blank ? 7'b1111111 : seg_decode(nib);
        end
    end

    always_ff @(posedge clock) begin : scan_regs
        if (!clear_n) begin
            refresh_q <= '0;
            digit_q   <= 2'd0;
            an_q      <= 3'b110;
            seg_q     <= 7'b1000000;
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy      = busy_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
